// File: rtl/ppu_pkg.sv
// Shared encodings, default raster timing and transfer FSM states for the
// pixel processing unit and its controller.
package ppu_pkg;

  localparam logic [2:0] MODE_PASS    = 3'd0;
  localparam logic [2:0] MODE_XORMOD  = 3'd1;
  localparam logic [2:0] MODE_STRIPES = 3'd2;
  localparam logic [2:0] MODE_RANDOM  = 3'd3;
  localparam logic [2:0] MODE_DIAG    = 3'd4;
  localparam logic [2:0] MODE_SHADOW  = 3'd5;

  localparam int DEF_H_TOTAL = 800;
  localparam int DEF_V_TOTAL = 525;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'd0,
    XFER_STB  = 2'd1,
    XFER_WAIT = 2'd2
  } xfer_state_t;

  // Auto-rotation order XORMOD..SHADOW; anything outside that range restarts at XORMOD.
  function automatic logic [2:0] next_auto_mode(input logic [2:0] m);
    if (m >= MODE_XORMOD && m < MODE_SHADOW) return m + 3'd1;
    return MODE_XORMOD;
  endfunction

endpackage

// File: rtl/ppu_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the other side only when
// a served transfer completes.
module ppu_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  input  logic done_b,
  output logic any_req,
  output logic win_b
);

  logic ptr_b_q;
  logic ptr_b_d;

  always_comb begin
    ptr_b_d = ptr_b_q;
    if (done) ptr_b_d = ~done_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_b_q <= 1'b0;
    else      ptr_b_q <= ptr_b_d;
  end

  assign any_req = req_a | req_b;
  assign win_b   = req_b & (~req_a | ptr_b_q);

endmodule

// File: rtl/ppu_ctrl.sv
// Sync/mode sequencer and byte feeder for the ppu. Optional automatic mode
// rotation is built when PPU_CTRL_AUTOCYCLE_EN is defined.
module ppu_ctrl
  import ppu_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int ACK_TIMEOUT = 15,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       auto_en,
  input  logic [2:0] mode_req,
  input  logic       mode_req_vld,
  input  logic       a_req,
  input  logic [7:0] a_data,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [7:0] b_data,
  output logic       b_gnt,
  output logic [7:0] ppu_data,
  output logic       ppu_stb,
  input  logic       ppu_ack,
  output logic       sync_o,
  output logic [2:0] mode_o,
  output logic       frame_start_o,
  output logic       err_o
);

  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(ACK_TIMEOUT);

  logic          sync_q, sync_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          frame_start_q, frame_start_d;
  logic [2:0]    mode_q, mode_d;
  logic [2:0]    pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          err_q, err_d;
  xfer_state_t   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          sel_b_q, sel_b_d;
  logic [7:0]    ppu_data_q, ppu_data_d;
  logic          ppu_stb_q, ppu_stb_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          wrap;
  logic          auto_step;
  logic          done;
  logic          timeout;
  logic          any_req;
  logic          win_b;

  // Raster mirror: held at 0 while sync is asserted, exactly like the ppu's sx/sy.
  always_comb begin
    sync_d = ~en;
    h_d    = h_q;
    v_d    = v_q;
    if (sync_q) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  assign wrap          = ~sync_q & (h_q == H_LAST) & (v_q == V_LAST);
  assign frame_start_d = wrap;

`ifdef PPU_CTRL_AUTOCYCLE_EN
  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);
  localparam logic [FW-1:0] HOLD_MAX  = FW'(HOLD_FRAMES);

  logic [FW-1:0] fcnt_q, fcnt_d;

  // The counter saturates so a late auto_en still steps at the next wrap.
  always_comb begin
    auto_step = wrap & auto_en & ~pend_vld_q & ~mode_req_vld & (fcnt_q >= HOLD_LAST);
    fcnt_d    = fcnt_q;
    if (mode_req_vld || (wrap && pend_vld_q) || auto_step) fcnt_d = '0;
    else if (wrap && fcnt_q != HOLD_MAX)                   fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fcnt_q <= '0;
    else      fcnt_q <= fcnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = auto_en & (HOLD_FRAMES > 0);
  assign auto_step  = 1'b0;
`endif

  // Requests land on a frame boundary unless the raster is stopped or already wrapping.
  always_comb begin
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (mode_req_vld && (wrap || !en)) begin
      mode_d     = mode_req;
      pend_vld_d = 1'b0;
    end else begin
      if (wrap && pend_vld_q) begin
        mode_d     = pend_q;
        pend_vld_d = 1'b0;
      end else if (auto_step) begin
        mode_d = next_auto_mode(mode_q);
      end
      if (mode_req_vld) begin
        pend_d     = mode_req;
        pend_vld_d = 1'b1;
      end
    end
  end

  ppu_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a   (a_req),
    .req_b   (b_req),
    .done    (done),
    .done_b  (sel_b_q),
    .any_req (any_req),
    .win_b   (win_b)
  );

  // Handshake: a requester holds req and data until its one-cycle gnt; ppu_stb
  // is a one-cycle strobe answered by ppu_ack, waited on for ACK_TIMEOUT cycles.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    sel_b_d    = sel_b_q;
    ppu_data_d = ppu_data_q;
    ppu_stb_d  = 1'b0;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      XFER_IDLE: begin
        if (en && any_req) begin
          sel_b_d    = win_b;
          ppu_data_d = win_b ? b_data : a_data;
          ppu_stb_d  = 1'b1;
          a_gnt_d    = ~win_b;
          b_gnt_d    = win_b;
          state_d    = XFER_STB;
        end
      end
      XFER_STB: begin
        tmr_d   = '0;
        state_d = XFER_WAIT;
      end
      XFER_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (ppu_ack) begin
          done    = 1'b1;
          state_d = XFER_IDLE;
        end else if (tmr_d == T_LIMIT) begin
          timeout = 1'b1;
          state_d = XFER_IDLE;
        end
      end
      default: state_d = XFER_IDLE;
    endcase
  end

  assign err_d = timeout | (err_q & en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q        <= 1'b1;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      mode_q        <= MODE_PASS;
      pend_q        <= MODE_PASS;
      pend_vld_q    <= 1'b0;
      err_q         <= 1'b0;
      state_q       <= XFER_IDLE;
      tmr_q         <= '0;
      sel_b_q       <= 1'b0;
      ppu_data_q    <= '0;
      ppu_stb_q     <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      err_q         <= err_d;
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      sel_b_q       <= sel_b_d;
      ppu_data_q    <= ppu_data_d;
      ppu_stb_q     <= ppu_stb_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
    end
  end

  assign sync_o        = sync_q;
  assign mode_o        = mode_q;
  assign frame_start_o = frame_start_q;
  assign err_o         = err_q;
  assign ppu_data      = ppu_data_q;
  assign ppu_stb       = ppu_stb_q;
  assign a_gnt         = a_gnt_q;
  assign b_gnt         = b_gnt_q;

endmodule
